// File: rtl/lab1_imul_int_mul_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter.
// Holds the FSM state enum and the operand/product widths.
package lab1_imul_ArbPkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int OPND_W = 64;
    localparam int PROD_W = 32;

endpackage

// File: rtl/lab1_imul_int_mul_arbiter_rr.sv
// Combinational requester picker: round-robin from i_ptr, or fixed
// lowest-index priority when LAB1_IMUL_ARB_FIXED_PRIO_EN is defined.
module lab1_imul_RoundRobinArb
    import lab1_imul_ArbPkg::*;
#(
    parameter int p_nreqs = 4,
    localparam int W = $clog2(p_nreqs)
) (
    input  logic [p_nreqs-1:0] i_val,
    input  logic [W-1:0]       i_ptr,
    output logic [p_nreqs-1:0] o_grant,
    output logic [W-1:0]       o_grant_idx,
    output logic               o_any
);

    always_comb begin
        logic         found;
        logic [W-1:0] idx;
`ifndef LAB1_IMUL_ARB_FIXED_PRIO_EN
        logic [W:0]   sum;
        sum = '0;
`endif
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = |i_val;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < p_nreqs; k++) begin
`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
            idx = W'(k);
`else
            // Candidate k steps past the pointer, wrapped into range.
            sum = {1'b0, i_ptr} + (W+1)'(k);
            if (sum >= (W+1)'(p_nreqs))
                sum = sum - (W+1)'(p_nreqs);
            idx = sum[W-1:0];
`endif
            if (!found && i_val[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/lab1_imul_int_mul_arbiter.sv
// Shares one iterative multiplier among p_nreqs val/rdy requesters.
// Optional macro LAB1_IMUL_ARB_FIXED_PRIO_EN selects fixed priority.
module lab1_imul_int_mul_arbiter
    import lab1_imul_ArbPkg::*;
#(
    parameter int p_nreqs = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [p_nreqs-1:0]       req_val,
    output logic [p_nreqs-1:0]       req_rdy,
    input  logic [OPND_W*p_nreqs-1:0] req_msg,
    output logic [p_nreqs-1:0]       resp_val,
    input  logic [p_nreqs-1:0]       resp_rdy,
    output logic [PROD_W*p_nreqs-1:0] resp_msg,
    output logic                     mul_istream_val,
    input  logic                     mul_istream_rdy,
    output logic [OPND_W-1:0]        mul_istream_msg,
    input  logic                     mul_ostream_val,
    output logic                     mul_ostream_rdy,
    input  logic [PROD_W-1:0]        mul_ostream_msg
);

    localparam int W = $clog2(p_nreqs);

    state_t             r_state;
    logic [W-1:0]       r_owner;
    logic [W-1:0]       r_ptr;

    logic [p_nreqs-1:0] w_grant;
    logic [W-1:0]       w_gidx;
    logic               w_any;
    logic [W-1:0]       w_next_ptr;
    logic               w_req_fire;
    logic               w_resp_fire;
    logic [OPND_W-1:0]  w_imsg;

    lab1_imul_RoundRobinArb #(
        .p_nreqs     (p_nreqs)
    ) u_arb (
        .i_val       (req_val),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    always_comb begin
        w_imsg = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (w_grant[i])
                w_imsg = req_msg[i*OPND_W +: OPND_W];
        end
    end

`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
    assign w_next_ptr = '0;
`else
    assign w_next_ptr = (w_gidx == W'(p_nreqs-1)) ? '0 : w_gidx + 1'b1;
`endif

    assign w_req_fire  = (r_state == IDLE) && w_any && mul_istream_rdy;
    assign w_resp_fire = (r_state == BUSY) && mul_ostream_val
                       && resp_rdy[r_owner];

    assign mul_istream_msg = w_imsg;
    assign resp_msg        = {p_nreqs{mul_ostream_msg}};

    // Handshake outputs stay quiet for the whole reset cycle.
    always_comb begin
        req_rdy         = '0;
        resp_val        = '0;
        mul_istream_val = 1'b0;
        mul_ostream_rdy = 1'b0;
        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    mul_istream_val = w_any;
                    req_rdy = w_grant & {p_nreqs{mul_istream_rdy}};
                end
                BUSY: begin
                    resp_val[r_owner] = mul_ostream_val;
                    mul_ostream_rdy   = resp_rdy[r_owner];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_owner <= w_gidx;
                        r_ptr   <= w_next_ptr;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_resp_fire)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab1_imul_int_mul_arbiter.sv
// Randomized self-checking bench for lab1_imul_int_mul_arbiter.
// Honours LAB1_IMUL_ARB_FIXED_PRIO_EN for the expected grant policy.
module tb_lab1_imul_int_mul_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_val;
    logic [N-1:0]     req_rdy;
    logic [64*N-1:0]  req_msg;
    logic [N-1:0]     resp_val;
    logic [N-1:0]     resp_rdy;
    logic [32*N-1:0]  resp_msg;
    logic             mul_istream_val;
    logic             mul_istream_rdy;
    logic [63:0]      mul_istream_msg;
    logic             mul_ostream_val;
    logic             mul_ostream_rdy;
    logic [31:0]      mul_ostream_msg;

    always #5 clk = ~clk;

    lab1_imul_int_mul_arbiter #(.p_nreqs(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_msg         (req_msg),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_msg        (resp_msg),
        .mul_istream_val (mul_istream_val),
        .mul_istream_rdy (mul_istream_rdy),
        .mul_istream_msg (mul_istream_msg),
        .mul_ostream_val (mul_ostream_val),
        .mul_ostream_rdy (mul_ostream_rdy),
        .mul_ostream_msg (mul_ostream_msg)
    );

    // Behavioural multiplier with a programmable latency range.
    logic        mb_busy = 1'b0;
    int          mb_cnt  = 0;
    logic [31:0] mb_prod = '0;
    int          lat_min, lat_max;

    assign mul_istream_rdy = !mb_busy;
    assign mul_ostream_val = mb_busy && (mb_cnt == 0);
    assign mul_ostream_msg = mb_prod;

    always @(posedge clk) begin
        if (reset) begin
            mb_busy <= 1'b0;
            mb_cnt  <= 0;
        end else if (!mb_busy) begin
            if (mul_istream_val) begin
                mb_busy <= 1'b1;
                mb_cnt  <= int'($urandom_range(lat_max, lat_min));
                mb_prod <= mul_istream_msg[63:32] * mul_istream_msg[31:0];
            end
        end else if (mb_cnt > 0) begin
            mb_cnt <= mb_cnt - 1;
        end else if (mul_ostream_rdy) begin
            mb_busy <= 1'b0;
        end
    end

    // Reference model state.
    logic [63:0] pend [N][$];
    int          m_ptr;
    bit          m_busy;
    int          m_owner;
    logic [31:0] m_exp;
    bit          fired [N];
    int          grants[$];
    int          gcyc[$];
    int          rcyc[$];
    logic [31:0] last_resp [N];
    logic [63:0] last_imsg;
    int          n_grant, n_resp, n_push;
    int          cyc;
    int          n_chk, n_err;
    bit          rand_gen, rr_rand;
    int          gen_left;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        int i;
        for (int k = 0; k < N; k++) begin
`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
            i = k;
`else
            i = (m_ptr + k) % N;
`endif
            if (req_val[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit outstanding();
        bit any;
        any = m_busy;
        for (int i = 0; i < N; i++)
            if (pend[i].size() != 0) any = 1'b1;
        return any;
    endfunction

    task automatic monitor();
        logic [N-1:0] ev;
        logic [31:0]  a, b;
        int           gi;
        if (reset) begin
            chk("rst_req_rdy", 64'(req_rdy), 64'd0);
            chk("rst_resp_val", 64'(resp_val), 64'd0);
            chk("rst_ival", 64'(mul_istream_val), 64'd0);
            chk("rst_ordy", 64'(mul_ostream_rdy), 64'd0);
            m_busy = 1'b0;
            m_ptr  = 0;
            for (int i = 0; i < N; i++) fired[i] = 1'b0;
            return;
        end
        if (m_busy) begin
            ev = '0;
            ev[m_owner] = mul_ostream_val;
            chk("busy_req_rdy", 64'(req_rdy), 64'd0);
            chk("busy_ival", 64'(mul_istream_val), 64'd0);
            chk("busy_resp_val", 64'(resp_val), 64'(ev));
            chk("busy_ordy", 64'(mul_ostream_rdy), 64'(resp_rdy[m_owner]));
            if (resp_val[m_owner] && resp_rdy[m_owner]) begin
                chk("resp_msg", 64'(resp_msg[32*m_owner +: 32]), 64'(m_exp));
                last_resp[m_owner] = resp_msg[32*m_owner +: 32];
                m_busy = 1'b0;
                rcyc.push_back(cyc);
                n_resp++;
            end
        end else begin
            chk("idle_resp_val", 64'(resp_val), 64'd0);
            chk("idle_ival", 64'(mul_istream_val), 64'(|req_val));
            gi = pick();
            if (gi >= 0) begin
                ev = '0;
                ev[gi] = mul_istream_rdy;
                chk("idle_req_rdy", 64'(req_rdy), 64'(ev));
                chk("idle_imsg", mul_istream_msg, req_msg[64*gi +: 64]);
                if (mul_istream_rdy) begin
                    a = req_msg[64*gi+32 +: 32];
                    b = req_msg[64*gi +: 32];
                    m_exp     = a * b;
                    last_imsg = mul_istream_msg;
                    m_busy    = 1'b1;
                    m_owner   = gi;
`ifndef LAB1_IMUL_ARB_FIXED_PRIO_EN
                    m_ptr = (gi + 1) % N;
`endif
                    fired[gi] = 1'b1;
                    grants.push_back(gi);
                    gcyc.push_back(cyc);
                    n_grant++;
                end
            end
        end
    endtask

    task automatic push(input int i, input logic [63:0] m);
        pend[i].push_back(m);
        n_push++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                void'(pend[i].pop_front());
                fired[i] = 1'b0;
            end
            if (rand_gen && gen_left > 0 && $urandom_range(3, 0) == 0) begin
                push(i, {$urandom, $urandom});
                gen_left--;
            end
        end
        for (int i = 0; i < N; i++) begin
            req_val[i] = (pend[i].size() != 0);
            req_msg[64*i +: 64] = req_val[i] ? pend[i][0] : 64'd0;
        end
        if (rr_rand) resp_rdy = N'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (outstanding() && b > 0) begin
            step();
            b--;
        end
        chk("drain_timeout", 64'(outstanding()), 64'd0);
    endtask

    task automatic clear_log();
        grants.delete();
        gcyc.delete();
        rcyc.delete();
    endtask

    initial begin
        int base_g, base_r;
        int b;
        reset = 1'b1;
        req_val = '0;
        req_msg = '0;
        resp_rdy = '1;
        lat_min = 2;
        lat_max = 2;
        rand_gen = 1'b0;
        rr_rand = 1'b0;
        gen_left = 0;
        n_chk = 0; n_err = 0; cyc = 0;
        n_grant = 0; n_resp = 0; n_push = 0;
        m_ptr = 0; m_busy = 1'b0; m_owner = 0; m_exp = '0;
        last_imsg = '0;
        for (int i = 0; i < N; i++) begin
            fired[i] = 1'b0;
            last_resp[i] = '0;
        end

        // All four valid from reset, two operands each.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                push(i, {32'(100 + 10*i + k), 32'(3 + i + k)});
        repeat (3) step();
        reset = 1'b0;
        clear_log();
        drain(300);
        chk("a_count", 64'(grants.size()), 64'd8);
`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
        chk("a_g0", 64'(grants[0]), 64'd0);
        chk("a_g1", 64'(grants[1]), 64'd0);
        chk("a_g2", 64'(grants[2]), 64'd1);
        chk("a_g3", 64'(grants[3]), 64'd1);
        chk("a_g4", 64'(grants[4]), 64'd2);
`else
        chk("a_g0", 64'(grants[0]), 64'd0);
        chk("a_g1", 64'(grants[1]), 64'd1);
        chk("a_g2", 64'(grants[2]), 64'd2);
        chk("a_g3", 64'(grants[3]), 64'd3);
        chk("a_g4", 64'(grants[4]), 64'd0);
`endif
        chk("a_prod3", 64'(last_resp[3]), 64'(32'd131 * 32'd7));

        // Single request 7 x 6 on requester 2.
        clear_log();
        push(2, {32'd7, 32'd6});
        drain(50);
        chk("b_grant", 64'(grants[0]), 64'd2);
        chk("b_imsg", last_imsg, {32'd7, 32'd6});
        chk("b_prod", 64'(last_resp[2]), 64'd42);

        // Owner 1 back-pressures its response for 10 cycles.
        clear_log();
        resp_rdy = 4'b1101;
        push(1, {32'd1234, 32'd5678});
        b = 50;
        while (!resp_val[1] && b > 0) begin
            step();
            b--;
        end
        chk("c_resp_wait", 64'(resp_val[1]), 64'd1);
        push(0, {32'd9, 32'd9});
        repeat (10) step();
        chk("c_no_grant", 64'(grants.size()), 64'd1);
        chk("c_ordy_low", 64'(mul_ostream_rdy), 64'd0);
        resp_rdy = '1;
        drain(50);
        chk("c_prod", 64'(last_resp[1]), 64'(32'd1234 * 32'd5678));
        chk("c_next", 64'(grants[1]), 64'd0);

        // Requester 3 raises val while requester 0 is multiplying.
        clear_log();
        push(0, {32'd11, 32'd13});
        step();
        step();
        step();
        push(3, {32'd17, 32'd19});
        drain(50);
        chk("d_order", 64'(grants[1]), 64'd3);
        chk("d_gap", 64'(gcyc[1] - rcyc[0]), 64'd1);
        chk("d_prod", 64'(last_resp[3]), 64'd323);

        // Reset in the middle of a multiply.
        clear_log();
        push(1, {32'd21, 32'd2});
        repeat (3) step();
        reset = 1'b1;
        for (int i = 0; i < N; i++) pend[i].delete();
        push(0, {32'hFFFF_FFFF, 32'd2});
        push(3, {32'd5, 32'd5});
        repeat (3) step();
        reset = 1'b0;
        clear_log();
        drain(50);
        chk("e_g0", 64'(grants[0]), 64'd0);
        chk("e_g1", 64'(grants[1]), 64'd3);
        chk("e_prod", 64'(last_resp[0]), 64'hFFFF_FFFE);

        // Random traffic, random latency and random response back-pressure.
        base_g = n_grant;
        base_r = n_resp;
        lat_min = 0;
        lat_max = 4;
        rand_gen = 1'b1;
        rr_rand = 1'b1;
        gen_left = 200;
        b = 6000;
        while (gen_left > 0 && b > 0) begin
            step();
            b--;
        end
        chk("f_gen_timeout", 64'(gen_left), 64'd0);
        drain(6000);
        chk("f_all_served", 64'(n_resp - base_r), 64'(n_grant - base_g));
        chk("f_total", 64'(n_resp - base_r), 64'd200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
